// File: rtl/dut_encoder_pkg.sv
// Shared types and helpers for the serialising request encoder.
package dut_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
  function automatic logic is_one_hot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/dut_prio_find.sv
// Combinational priority finder: index and mask of the lowest (or highest) set bit.
module dut_prio_find #(
  parameter int  N         = 4,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int W         = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // The loop runs away from the preferred end so the last hit wins.
  always_comb begin
    idx    = '0;
    onehot = '0;
    if (!MSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx       = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          idx       = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dut_encoder_serial_n.sv
// Serialising encoder: accepts an N-bit request vector and emits the index of
// every set bit, one per output beat, with last marking the final index.
module dut_encoder_serial_n
  import dut_encoder_pkg::*;
#(
  parameter int  N         = 4,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         last,
  output logic         zero_det
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and data until that edge, and ready may
  // depend combinationally on the other side's valid/ready.
  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] sel_mask;
  logic         accept;
  logic         retire;

  dut_prio_find #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_find (
    .vec    (pending),
    .idx    (y),
    .onehot (sel_mask)
  );

  // pending is zero whenever the FSM idles, so y and last read 0 there.
  assign last      = is_one_hot(64'(pending));
  assign out_valid = (state == ST_SCAN);
  assign retire    = out_valid && out_ready;
  assign in_ready  = !rst && ((state == ST_IDLE) || (retire && last));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= '0;
      zero_det <= 1'b0;
    end else begin
      zero_det <= accept && (d == '0);
      if (accept) begin
        // Also covers the back-to-back case where the last beat retires now.
        pending <= d;
        state   <= (d != '0) ? ST_SCAN : ST_IDLE;
      end else if (retire) begin
        pending <= pending & ~sel_mask;
        if (last) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_encoder_serial_n.sv
// Bench for dut_encoder_serial_n: three instances (N=4 lsb-first, N=4
// msb-first, N=8 lsb-first) checked cycle by cycle against a queue model.
module tb_dut_encoder_serial_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid_v  [3];
  logic       out_ready_v [3];
  logic [7:0] d_v         [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       last_v      [3];
  logic       zero_v      [3];
  logic [2:0] y_v         [3];
  logic [1:0] y_a, y_b;
  logic [2:0] y_c;

  int n_of   [3] = '{4, 4, 8};
  bit msb_of [3] = '{1'b0, 1'b1, 1'b0};

  int checks   = 0;
  int failures = 0;

  // Expected beats of the active instance: bit 3 = last, bits 2:0 = index.
  logic [3:0] exp_q[$];
  logic       zero_exp = 1'b0;

  always #5 clk = ~clk;

  assign y_v[0] = {1'b0, y_a};
  assign y_v[1] = {1'b0, y_b};
  assign y_v[2] = y_c;

  dut_encoder_serial_n #(.N(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .d(d_v[0][3:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .y(y_a), .last(last_v[0]), .zero_det(zero_v[0]));

  dut_encoder_serial_n #(.N(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .d(d_v[1][3:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .y(y_b), .last(last_v[1]), .zero_det(zero_v[1]));

  dut_encoder_serial_n #(.N(8), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .d(d_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .y(y_c), .last(last_v[2]), .zero_det(zero_v[2]));

  // Reference: list the set bits of v in emission order, flagging the final one.
  task automatic push_vector(input int k, input logic [7:0] v);
    int cnt;
    int seen;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < n_of[k]; i++) if (v[i]) cnt++;
    if (!msb_of[k]) begin
      for (int i = 0; i < n_of[k]; i++)
        if (v[i]) begin seen++; exp_q.push_back({seen == cnt, 3'(i)}); end
    end else begin
      for (int i = n_of[k] - 1; i >= 0; i--)
        if (v[i]) begin seen++; exp_q.push_back({seen == cnt, 3'(i)}); end
    end
  endtask

  // One clock of instance k: drive at negedge, check outputs, advance the model.
  task automatic run_cycle(input int k, input logic iv, input logic [7:0] dv,
                           input logic ordy, output logic acc);
    logic       exp_vld;
    logic       exp_rdy;
    logic [3:0] exp_beat;
    logic [7:0] masked;
    @(negedge clk);
    in_valid_v[k]  = iv;
    d_v[k]         = dv;
    out_ready_v[k] = ordy;
    #1;
    exp_vld  = (exp_q.size() != 0);
    exp_beat = exp_vld ? exp_q[0] : 4'h0;
    exp_rdy  = !exp_vld || (ordy && exp_beat[3]);

    checks++;
    if (out_valid_v[k] !== exp_vld) begin
      failures++;
      $display("FAIL out_valid inst=%0d got=%b exp=%b", k, out_valid_v[k], exp_vld);
    end
    checks++;
    if ({last_v[k], y_v[k]} !== exp_beat) begin
      failures++;
      $display("FAIL beat inst=%0d got last=%b y=%0d exp last=%b y=%0d",
               k, last_v[k], y_v[k], exp_beat[3], exp_beat[2:0]);
    end
    checks++;
    if (in_ready_v[k] !== exp_rdy) begin
      failures++;
      $display("FAIL in_ready inst=%0d got=%b exp=%b", k, in_ready_v[k], exp_rdy);
    end
    checks++;
    if (zero_v[k] !== zero_exp) begin
      failures++;
      $display("FAIL zero_det inst=%0d got=%b exp=%b", k, zero_v[k], zero_exp);
    end

    acc    = iv && exp_rdy;
    masked = dv & 8'((1 << n_of[k]) - 1);
    if (exp_vld && ordy) void'(exp_q.pop_front());
    zero_exp = acc && (masked == 8'h00);
    if (acc && masked != 8'h00) push_vector(k, masked);
  endtask

  task automatic drain(input int k);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      run_cycle(k, 1'b0, 8'h00, 1'b1, acc);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout inst=%0d left=%0d exp=0", k, exp_q.size());
      exp_q.delete();
    end
    run_cycle(k, 1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0; d_v[i] = 8'h00; out_ready_v[i] = 1'b1;
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL in_ready_in_reset inst=%0d got=%b exp=0", i, in_ready_v[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    zero_exp = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || y_v[i] !== 3'd0 ||
          last_v[i] !== 1'b0 || zero_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values inst=%0d got rdy=%b vld=%b y=%0d last=%b zd=%b exp 1 0 0 0 0",
                 i, in_ready_v[i], out_valid_v[i], y_v[i], last_v[i], zero_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic acc;
    do_reset();
    for (int k = 0; k < 3; k++) run_cycle(k, 1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic test_onehot();
    logic acc;
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 1'b1, 8'(1 << i), 1'b1, acc);
      run_cycle(0, 1'b0, 8'h00, 1'b1, acc);
    end
    drain(0);
  endtask

  task automatic test_priority_order();
    logic acc;
    for (int k = 0; k < 2; k++) begin
      run_cycle(k, 1'b1, 8'b1010, 1'b1, acc);
      drain(k);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    run_cycle(2, 1'b1, 8'hFF, 1'b1, acc);
    for (int c = 0; c < 16; c++) run_cycle(2, 1'b0, 8'h00, 1'(c % 2 == 0), acc);
    drain(2);
  endtask

  task automatic test_back_to_back();
    logic acc;
    run_cycle(0, 1'b1, 8'b0100, 1'b1, acc);
    run_cycle(0, 1'b1, 8'b0011, 1'b1, acc);
    drain(0);
    run_cycle(0, 1'b1, 8'b0100, 1'b1, acc);
    run_cycle(0, 1'b1, 8'b0000, 1'b1, acc);
    drain(0);
  endtask

  task automatic test_zero_vector();
    logic acc;
    run_cycle(0, 1'b1, 8'h00, 1'b1, acc);
    run_cycle(0, 1'b0, 8'h00, 1'b1, acc);
    run_cycle(0, 1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic test_reset_mid_scan();
    logic acc;
    run_cycle(2, 1'b1, 8'h81, 1'b1, acc);
    run_cycle(2, 1'b0, 8'h00, 1'b1, acc);
    do_reset();
    run_cycle(2, 1'b0, 8'h00, 1'b1, acc);
    run_cycle(2, 1'b1, 8'h81, 1'b1, acc);
    drain(2);
  endtask

  task automatic test_random(input int k, input int cycles);
    logic       iv;
    logic       acc;
    logic [7:0] dv;
    iv = 1'b0;
    dv = 8'h00;
    for (int c = 0; c < cycles; c++) begin
      if (!iv && $urandom_range(0, 2) != 0) begin
        iv = 1'b1;
        dv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      run_cycle(k, iv, iv ? dv : 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
      if (acc) iv = 1'b0;
    end
    drain(k);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0; d_v[i] = 8'h00; out_ready_v[i] = 1'b1;
    end
    test_reset();
    test_onehot();
    test_priority_order();
    test_backpressure();
    test_back_to_back();
    test_zero_vector();
    test_reset_mid_scan();
    for (int k = 0; k < 3; k++) test_random(k, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
